// File: rtl/ysyx_24100006_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// Signal names match the memory model's DPI-C port names.
interface ysyx_24100006_lsu_if;
    logic        Mem_Read;
    logic [31:0] raddr;
    logic        Mem_Write;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  Mem_WMask;
    logic [31:0] rdata;

    modport master (
        output Mem_Read, raddr, Mem_Write, waddr, wdata, Mem_WMask,
        input  rdata
    );

    modport slave (
        input  Mem_Read, raddr, Mem_Write, waddr, wdata, Mem_WMask,
        output rdata
    );
endinterface

// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit: takes one memory op from EXU, drives the data-memory bus with
// word-aligned address, lane-shifted data and byte mask, and hands aligned load data to WBU.
module ysyx_24100006_lsu #(
    parameter int RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic [1:0]                  in_size,
    input  logic                        in_unsigned,
    input  logic [31:0]                 in_addr,
    input  logic [31:0]                 in_wdata,
    ysyx_24100006_lsu_if.master         mem,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_rdata,
    output logic                        out_misalign
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LREQ,
        LWAIT,
        SREQ,
        DONE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    size_reg;
    logic [1:0]    lo_reg;
    logic          uns_reg;

    logic          is_load;
    logic          is_store;
    logic          misalign;
    logic [3:0]    mask_base;
    logic [31:0]   lane;
    logic [31:0]   load_ext;

    always_comb begin
        is_load   = (in_op == 2'b01);
        is_store  = (in_op == 2'b10);
        misalign  = 1'b0;
        mask_base = 4'b1111;
        case (in_size)
            2'b00: begin
                misalign  = 1'b0;
                mask_base = 4'b0001;
            end
            2'b01: begin
                misalign  = in_addr[0];
                mask_base = 4'b0011;
            end
            default: begin
                misalign  = |in_addr[1:0];
                mask_base = 4'b1111;
            end
        endcase

        // Aligned ops guarantee the selected lane starts at bit 0 after this shift.
        lane     = mem.rdata >> {lo_reg, 3'b000};
        load_ext = mem.rdata;
        case (size_reg)
            2'b00:   load_ext = {{24{~uns_reg & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{~uns_reg & lane[15]}}, lane[15:0]};
            default: load_ext = mem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            size_reg      <= 2'b00;
            lo_reg        <= 2'b00;
            uns_reg       <= 1'b0;
            in_ready      <= 1'b1;
            mem.Mem_Read  <= 1'b0;
            mem.raddr     <= 32'h0;
            mem.Mem_Write <= 1'b0;
            mem.waddr     <= 32'h0;
            mem.wdata     <= 32'h0;
            mem.Mem_WMask <= 8'h00;
            out_valid     <= 1'b0;
            out_rdata     <= 32'h0;
            out_misalign  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        size_reg <= in_size;
                        lo_reg   <= in_addr[1:0];
                        uns_reg  <= in_unsigned;
                        // Only real memory ops can be misaligned; none/reserved finish clean.
                        if (!(is_load || is_store) || misalign) begin
                            out_valid    <= 1'b1;
                            out_rdata    <= 32'h0;
                            out_misalign <= (is_load || is_store) && misalign;
                            state_reg    <= DONE;
                        end else if (is_load) begin
                            mem.Mem_Read <= 1'b1;
                            mem.raddr    <= {in_addr[31:2], 2'b00};
                            state_reg    <= LREQ;
                        end else begin
                            mem.Mem_Write <= 1'b1;
                            mem.waddr     <= {in_addr[31:2], 2'b00};
                            mem.wdata     <= in_wdata << {in_addr[1:0], 3'b000};
                            mem.Mem_WMask <= {4'b0000, mask_base << in_addr[1:0]};
                            state_reg     <= SREQ;
                        end
                    end
                end
                LREQ: begin
                    mem.Mem_Read <= 1'b0;
                    mem.raddr    <= 32'h0;
                    cnt_reg      <= CW'(RD_LAT - 1);
                    state_reg    <= LWAIT;
                end
                LWAIT: begin
                    if (cnt_reg == '0) begin
                        out_rdata <= load_ext;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SREQ: begin
                    mem.Mem_Write <= 1'b0;
                    mem.waddr     <= 32'h0;
                    mem.wdata     <= 32'h0;
                    mem.Mem_WMask <= 8'h00;
                    out_valid     <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        out_rdata    <= 32'h0;
                        out_misalign <= 1'b0;
                        in_ready     <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Bench for ysyx_24100006_lsu: one instance with RD_LAT=1 and one with RD_LAT=3, a
// registered-read memory that drives junk outside the valid read cycle, and a byte-level model.
module tb_ysyx_24100006_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid_a   [2];
    logic        in_ready_a   [2];
    logic [1:0]  in_op_a      [2];
    logic [1:0]  in_size_a    [2];
    logic        in_uns_a     [2];
    logic [31:0] in_addr_a    [2];
    logic [31:0] in_wdata_a   [2];
    logic        out_valid_a  [2];
    logic        out_ready_a  [2];
    logic [31:0] out_rdata_a  [2];
    logic        out_mis_a    [2];
    logic        mrd_a        [2];
    logic        mwr_a        [2];
    logic [31:0] raddr_a      [2];
    logic [31:0] waddr_a      [2];
    logic [31:0] wdata_a      [2];
    logic [7:0]  wmask_a      [2];
    logic [31:0] rdata_a      [2];

    logic [31:0] dmem  [2][256];
    logic        pv    [2][3];
    logic [31:0] pd    [2][3];
    logic [31:0] junk  [2];

    logic [7:0]  ref_bytes [2][1024];
    int checks = 0;
    int failures = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            ysyx_24100006_lsu_if u_bus ();
            ysyx_24100006_lsu #(.RD_LAT(LAT)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .in_valid     (in_valid_a[gi]),
                .in_ready     (in_ready_a[gi]),
                .in_op        (in_op_a[gi]),
                .in_size      (in_size_a[gi]),
                .in_unsigned  (in_uns_a[gi]),
                .in_addr      (in_addr_a[gi]),
                .in_wdata     (in_wdata_a[gi]),
                .mem          (u_bus),
                .out_valid    (out_valid_a[gi]),
                .out_ready    (out_ready_a[gi]),
                .out_rdata    (out_rdata_a[gi]),
                .out_misalign (out_mis_a[gi])
            );
            assign mrd_a[gi]     = u_bus.Mem_Read;
            assign mwr_a[gi]     = u_bus.Mem_Write;
            assign raddr_a[gi]   = u_bus.raddr;
            assign waddr_a[gi]   = u_bus.waddr;
            assign wdata_a[gi]   = u_bus.wdata;
            assign wmask_a[gi]   = u_bus.Mem_WMask;
            assign rdata_a[gi]   = pv[gi][LAT-1] ? pd[gi][LAT-1] : junk[gi];
            assign u_bus.rdata   = rdata_a[gi];
        end
    endgenerate

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [7:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory: read sampled on the Mem_Read edge, data visible RD_LAT edges later, junk otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            junk[d] <= $urandom;
            if (mwr_a[d])
                dmem[d][waddr_a[d][9:2]] <= merge(dmem[d][waddr_a[d][9:2]], wdata_a[d], wmask_a[d]);
            pv[d][0] <= mrd_a[d];
            pd[d][0] <= dmem[d][raddr_a[d][9:2]];
            for (int s = 1; s < 3; s++) begin
                pv[d][s] <= pv[d][s-1];
                pd[d][s] <= pd[d][s-1];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic mis_of(input logic [1:0] op, input logic [1:0] size,
                                    input logic [31:0] addr);
        return ((op == 2'b01) || (op == 2'b10)) && ((int'(addr[1:0]) % nbytes(size)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_bytes[d][10'(addr[9:0] + i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_flags"}, {in_ready_a[d], mrd_a[d], mwr_a[d], out_valid_a[d], out_mis_a[d]},
            5'b10000);
        chk({tag, "_data"}, raddr_a[d] | waddr_a[d] | wdata_a[d] | out_rdata_a[d] | {24'h0, wmask_a[d]},
            0);
    endtask

    task automatic run_op(input int d, input logic [1:0] op, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat,
                          input int hold);
        int nb, cyc, nrd, nwr, bad, bad_hold, m;
        logic memop, mis_m, got;
        logic [31:0] e_addr, e_wd, rd_hold;
        logic [7:0] e_mask;
        nb     = nbytes(size);
        memop  = (op == 2'b01) || (op == 2'b10);
        mis_m  = mis_of(op, size, addr);
        e_addr = {addr[31:2], 2'b00};
        e_wd   = wd << (8 * int'(addr[1:0]));
        m      = ((1 << nb) - 1) << int'(addr[1:0]);
        e_mask = 8'(m);
        @(negedge clk);
        chk("in_ready", in_ready_a[d], 1);
        in_op_a[d] = op; in_size_a[d] = size; in_uns_a[d] = uns;
        in_addr_a[d] = addr; in_wdata_a[d] = wd; in_valid_a[d] = 1'b1;
        @(posedge clk);
        #1 in_valid_a[d] = 1'b0;
        cyc = 0; got = 1'b0; nrd = 0; nwr = 0; bad = 0; bad_hold = 0;
        while (!got && cyc < 24) begin
            @(negedge clk);
            cyc++;
            if (in_ready_a[d]) bad++;
            if (mrd_a[d]) begin
                nrd++;
                if (raddr_a[d] !== e_addr) bad++;
            end else if (raddr_a[d] !== 32'h0) bad++;
            if (mwr_a[d]) begin
                nwr++;
                if (waddr_a[d] !== e_addr || wdata_a[d] !== e_wd || wmask_a[d] !== e_mask) bad++;
            end else if ((waddr_a[d] | wdata_a[d] | {24'h0, wmask_a[d]}) !== 32'h0) bad++;
            if (mrd_a[d] && mwr_a[d]) bad++;
            if (out_valid_a[d]) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("latency", cyc, exp_lat);
        chk("rd_pulses", nrd, (op == 2'b01 && !mis_m) ? 1 : 0);
        chk("wr_pulses", nwr, (op == 2'b10 && !mis_m) ? 1 : 0);
        chk("bus_vals", bad, 0);
        chk("out_rdata", out_rdata_a[d], exp_rd);
        chk("out_misalign", out_mis_a[d], exp_mis);
        rd_hold = out_rdata_a[d];
        if (hold > 0) begin
            // A competing store is presented while the result waits; it must be ignored.
            in_op_a[d] = 2'b10; in_size_a[d] = 2'b10; in_addr_a[d] = 32'h8000_0020;
            in_wdata_a[d] = 32'h5555_AAAA; in_valid_a[d] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!out_valid_a[d] || out_rdata_a[d] !== rd_hold || in_ready_a[d] ||
                    mrd_a[d] || mwr_a[d]) bad_hold++;
            end
            in_valid_a[d] = 1'b0;
            chk("hold_stable", bad_hold, 0);
        end
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        #1 out_ready_a[d] = 1'b0;
        chk("release", {out_valid_a[d], in_ready_a[d]}, 2'b01);
        if (op == 2'b10 && !mis_m)
            for (int i = 0; i < nb; i++)
                ref_bytes[d][10'(addr[9:0] + i)] = wd[8*i +: 8];
        $display("txn dut=%0d op=%0d size=%0d uns=%0d addr=%h wd=%h -> rdata=%h mis=%0d lat=%0d",
                 d, op, size, uns, addr, wd, rd_hold, exp_mis, cyc);
        if (!memop && exp_mis) $display("note: non-memory op flagged misaligned by table");
    endtask

    task automatic rand_op(input int d);
        logic [1:0] op, size;
        logic uns, mis;
        logic [31:0] addr, wd, rd;
        int lat;
        op   = 2'($urandom_range(0, 3));
        size = 2'($urandom_range(0, 3));
        uns  = 1'($urandom_range(0, 1));
        addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
        wd   = $urandom;
        mis  = mis_of(op, size, addr);
        rd   = (op == 2'b01 && !mis) ? model_load(d, size, uns, addr) : 32'h0;
        if (!(op == 2'b01 || op == 2'b10) || mis) lat = 1;
        else if (op == 2'b10) lat = 2;
        else lat = 2 + lat_of(d);
        run_op(d, op, size, uns, addr, wd, rd, mis, lat, $urandom_range(0, 2));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{2'b10, 2'b10, 1'b0, 32'h8000_0000, 32'h80AB_CDEF, 32'h0000_0000, 1'b0, 2, 0};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 5};
        tbl[2]  = '{2'b01, 2'b00, 1'b1, 32'h8000_0003, 32'h0,         32'h0000_0080, 1'b0, 3, 0};
        tbl[3]  = '{2'b10, 2'b01, 1'b0, 32'h8000_0002, 32'h0000_1234, 32'h0000_0000, 1'b0, 2, 0};
        tbl[4]  = '{2'b01, 2'b10, 1'b0, 32'h8000_0000, 32'h0,         32'h1234_CDEF, 1'b0, 3, 0};
        tbl[5]  = '{2'b01, 2'b10, 1'b0, 32'h8000_0001, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        tbl[6]  = '{2'b00, 2'b10, 1'b0, 32'h8000_0001, 32'h0,         32'h0000_0000, 1'b0, 1, 0};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b0, 1, 0};
        tbl[8]  = '{2'b01, 2'b01, 1'b0, 32'h8000_0002, 32'h0,         32'h0000_1234, 1'b0, 3, 0};
        tbl[9]  = '{2'b01, 2'b01, 1'b0, 32'h8000_0000, 32'h0,         32'hFFFF_CDEF, 1'b0, 3, 0};
        tbl[10] = '{2'b01, 2'b01, 1'b1, 32'h8000_0000, 32'h0,         32'h0000_CDEF, 1'b0, 3, 0};
        tbl[11] = '{2'b01, 2'b01, 1'b0, 32'h8000_0001, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        tbl[12] = '{2'b10, 2'b11, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0};
        tbl[13] = '{2'b01, 2'b11, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0};
        tbl[14] = '{2'b10, 2'b00, 1'b0, 32'h8000_0005, 32'h0000_00AA, 32'h0000_0000, 1'b0, 2, 0};
        tbl[15] = '{2'b01, 2'b00, 1'b1, 32'h8000_0005, 32'h0,         32'h0000_00AA, 1'b0, 3, 0};
        tbl[16] = '{2'b01, 2'b10, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_AAEF, 1'b0, 3, 0};
        tbl[17] = '{2'b01, 2'b00, 1'b0, 32'h8000_0001, 32'h0,         32'hFFFF_FFCD, 1'b0, 3, 0};
        tbl[18] = '{2'b10, 2'b01, 1'b0, 32'h8000_0003, 32'h0000_7777, 32'h0000_0000, 1'b1, 1, 0};

        for (int d = 0; d < 2; d++) begin
            in_valid_a[d] = 1'b0; in_op_a[d] = 2'b00; in_size_a[d] = 2'b00;
            in_uns_a[d] = 1'b0; in_addr_a[d] = 32'h0; in_wdata_a[d] = 32'h0;
            out_ready_a[d] = 1'b0;
            for (int i = 0; i < 1024; i++) ref_bytes[d][i] = 8'h00;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        rst = 1'b0;

        // Reset held three cycles while a load is in flight.
        @(negedge clk);
        in_op_a[0] = 2'b01; in_size_a[0] = 2'b10; in_addr_a[0] = 32'h8000_0000;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1 in_valid_a[0] = 1'b0;
        @(negedge clk);
        chk("mid_rd", mrd_a[0], 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle(0, "midrst");
        end
        rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "postrst");
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (out_valid_a[0] || mrd_a[0] || mwr_a[0]) stray++;
            end
            chk("abort_quiet", stray, 0);
        end
        $display("txn reset mid-load done");

        for (int i = 0; i < 19; i++)
            run_op(0, tbl[i].op, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                   tbl[i].exp_rd, tbl[i].exp_mis, tbl[i].exp_lat, tbl[i].hold);

        // Longer read latency: data must come from the valid cycle, not the junk before it.
        run_op(1, 2'b10, 2'b10, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0);
        run_op(1, 2'b01, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 5, 0);
        run_op(1, 2'b01, 2'b00, 1'b0, 32'h8000_0011, 32'h0, 32'hFFFF_FFF0, 1'b0, 5, 3);

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                run_op(d, 2'b10, 2'b10, 1'b0, 32'h8000_0000 + 32'(4 * w), $urandom,
                       32'h0, 1'b0, 2, 0);

        for (int i = 0; i < 150; i++) rand_op(0);
        for (int i = 0; i < 40; i++) rand_op(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end
endmodule
